// File: rtl/mod_4051_pkg.sv
// Shared constants and types for the mod-4051 reduction datapath.
// The per-chunk residue LUT stage uses the same constants.
package mod_4051_pkg;

    localparam int MOD        = 4051;
    localparam int W          = 12;
    localparam int NUM_CHUNKS = 84;
    localparam int CNT_W      = 7;

    typedef logic [W-1:0] residue_t;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

endpackage

// File: rtl/mod_4051_add.sv
// Combinational modular adder: y = (a + b) mod MOD.
// A single conditional subtract is enough whenever a + b < 2*MOD. This holds
// when both operands are already reduced. It also holds when b is 0 and a is
// any W-bit value, because 2^W - 1 < 2*MOD.
module mod_4051_add #(
    parameter int MOD = mod_4051_pkg::MOD,
    parameter int W   = mod_4051_pkg::W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    localparam logic [W:0] MOD_EXT = (W+1)'(MOD);

    logic [W:0]   sum_wide;
    logic [W-1:0] sum_sub;

    // Add with one guard bit, then subtract MOD once if the sum reached it.
    // When the subtract is taken the true difference is below MOD and fits in
    // W bits, so the low W bits of the subtraction are exact.
    always_comb begin
        sum_wide = {1'b0, a} + {1'b0, b};
        sum_sub  = sum_wide[W-1:0] - MOD_EXT[W-1:0];
        y        = (sum_wide >= MOD_EXT) ? sum_sub : sum_wide[W-1:0];
    end

endmodule

// File: rtl/mod_4051_residue_accum.sv
// Running mod-4051 accumulator for the per-chunk residue LUT outputs.
// It accepts NUM_CHUNKS partial residues per operand and then presents the
// final residue until the downstream stage consumes it. chunk_idx tells the
// upstream mux which LUT to select next.
module mod_4051_residue_accum #(
    parameter int MOD        = mod_4051_pkg::MOD,
    parameter int W          = mod_4051_pkg::W,
    parameter int NUM_CHUNKS = mod_4051_pkg::NUM_CHUNKS,
    parameter int CNT_W      = mod_4051_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_residue,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CNT_W-1:0] chunk_idx,
    output logic [W-1:0]     out_residue,
    output logic             out_valid,
    input  logic             out_ready
);

    import mod_4051_pkg::*;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [W-1:0]     ZERO     = '0;

    state_t           state_reg, state_next;
    logic [W-1:0]     acc_reg, acc_next;
    logic [W-1:0]     out_reg, out_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // r is the raw LUT value brought below MOD; sum is acc + r mod MOD.
    logic [W-1:0]     norm_residue;
    logic [W-1:0]     sum_residue;

    // Adding zero reduces any W-bit input through the adder's single subtract.
    mod_4051_add #(.MOD(MOD), .W(W)) u_norm (
        .a (in_residue),
        .b (ZERO),
        .y (norm_residue)
    );

    mod_4051_add #(.MOD(MOD), .W(W)) u_accum (
        .a (acc_reg),
        .b (norm_residue),
        .y (sum_residue)
    );

    // State, accumulator, chunk counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            out_reg   <= out_next;
        end
    end

    // Next-state logic. In ACCUM in_ready is 1, so in_valid alone means an
    // accept. The last chunk moves the sum into the result register. It also
    // clears acc, so chunk 0 of the next operand starts from zero.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        out_next   = out_reg;
        case (state_reg)
            ACCUM: begin
                if (in_valid) begin
                    if (cnt_reg == LAST_IDX) begin
                        out_next   = sum_residue;
                        acc_next   = '0;
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        acc_next   = sum_residue;
                        cnt_next   = cnt_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // Handshake outputs decode only registered state.
    assign in_ready    = (state_reg == ACCUM);
    assign out_valid   = (state_reg == DONE);
    assign chunk_idx   = cnt_reg;
    assign out_residue = out_reg;

endmodule

// File: tb/tb_mod_4051_residue_accum.sv
// Self-checking bench for mod_4051_residue_accum.
// A table of operands drives the main checks. A scoreboard queue holds the
// expected residues. Hand-written sequences cover result hold, ignored inputs
// in DONE and asynchronous reset.
module tb_mod_4051_residue_accum;

    import mod_4051_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     in_residue;
    logic             in_valid;
    logic             in_ready;
    logic [CNT_W-1:0] chunk_idx;
    logic [W-1:0]     out_residue;
    logic             out_valid;
    logic             out_ready;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    typedef struct {
        int c0;
        int c1;
        int fill;
        int expv;
    } vec_t;

    vec_t tbl[7];

    mod_4051_residue_accum dut (
        .clk         (clk),
        .rst         (rst),
        .in_residue  (in_residue),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .chunk_idx   (chunk_idx),
        .out_residue (out_residue),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Reference: reduce every chunk, then sum modulo MOD in integer arithmetic.
    function automatic int model(input int c0, input int c1, input int fill);
        int acc = 0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            int v = (i == 0) ? c0 : ((i == 1) ? c1 : fill);
            acc = (acc + (v % MOD)) % MOD;
        end
        return acc;
    endfunction

    // Drive one operand with in_valid held high. Inputs change on negedges.
    // The task returns on the negedge after the last accept.
    task automatic feed(input string tag, input int c0, input int c1, input int fill, input int expv);
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            @(negedge clk);
            chk({tag, " chunk_idx"}, int'(chunk_idx), i);
            chk({tag, " in_ready"}, int'(in_ready), 1);
            in_residue = W'((i == 0) ? c0 : ((i == 1) ? c1 : fill));
            in_valid   = 1'b1;
            if (i == NUM_CHUNKS - 1) exp_q.push_back(expv);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " latency out_valid"}, int'(out_valid), 1);
    endtask

    // Compare the result against the scoreboard, then complete the handshake.
    task automatic collect(input string tag);
        int n = 0;
        int expv;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk({tag, " result timeout"}, 0, 1);
        end else if (exp_q.size() == 0) begin
            chk({tag, " unexpected result"}, 1, 0);
        end else begin
            expv = exp_q.pop_front();
            chk({tag, " out_residue"}, int'(out_residue), expv);
            chk({tag, " in_ready in DONE"}, int'(in_ready), 0);
            $display("%s: residue=%0d expected=%0d", tag, out_residue, expv);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid after handshake"}, int'(out_valid), 0);
        chk({tag, " in_ready after handshake"}, int'(in_ready), 1);
        chk({tag, " chunk_idx after handshake"}, int'(chunk_idx), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"}, int'(in_ready), 1);
        chk({tag, " out_valid"}, int'(out_valid), 0);
        chk({tag, " chunk_idx"}, int'(chunk_idx), 0);
        chk({tag, " out_residue"}, int'(out_residue), 0);
    endtask

    initial begin
        int rc0, rc1, rfill;

        tbl[0] = '{c0: 0,    c1: 0,    fill: 0,    expv: 0};
        tbl[1] = '{c0: 4050, c1: 4050, fill: 4050, expv: 3967};
        tbl[2] = '{c0: 4095, c1: 0,    fill: 0,    expv: 44};
        tbl[3] = '{c0: 2000, c1: 2100, fill: 0,    expv: 49};
        tbl[4] = '{c0: 1,    c1: 1,    fill: 1,    expv: 84};
        tbl[5] = '{c0: 4095, c1: 4095, fill: 4095, expv: 3696};
        tbl[6] = '{c0: 4051, c1: 4051, fill: 4051, expv: 0};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_residue = '0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Table-driven operands.
        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            feed(tag, tbl[i].c0, tbl[i].c1, tbl[i].fill, tbl[i].expv);
            collect(tag);
        end

        // Random operands checked against the integer model.
        for (int k = 0; k < 3; k++) begin
            string tag;
            tag   = $sformatf("rand%0d", k);
            rc0   = int'($urandom_range(4095, 0));
            rc1   = int'($urandom_range(4095, 0));
            rfill = int'($urandom_range(4095, 0));
            feed(tag, rc0, rc1, rfill, model(rc0, rc1, rfill));
            collect(tag);
        end

        // Hold the result for 5 cycles while pulsing in_valid. The next operand
        // of ones must give 84, which shows that no pulse was accepted.
        feed("hold", 2000, 2100, 0, 49);
        for (int k = 0; k < 5; k++) begin
            chk("hold out_valid", int'(out_valid), 1);
            chk("hold out_residue", int'(out_residue), 49);
            chk("hold in_ready", int'(in_ready), 0);
            in_valid   = k[0] ? 1'b0 : 1'b1;
            in_residue = W'(123);
            @(negedge clk);
        end
        in_valid = 1'b0;
        collect("hold");
        feed("after_hold", 1, 1, 1, 84);
        collect("after_hold");

        // Assert reset after 40 chunks of 7. The 280 already summed must vanish.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in_residue = W'(7);
            in_valid   = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid chunk_idx", int'(chunk_idx), 40);
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        feed("post_rst", 1, 1, 1, 84);
        collect("post_rst");

        // Assert reset while a result is pending. The result must be discarded.
        feed("pend", 4050, 4050, 4050, 3967);
        void'(exp_q.pop_front());
        rst = 1'b1;
        #1;
        chk_reset_vals("pend_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        feed("after_pend", 0, 0, 5, 410);
        collect("after_pend");

        chk("scoreboard empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
